// File: rtl/qr_err_search.sv
// Sequential error-pattern search for the QR (73,37) decoder: walks all
// combinations of 0..MAX_ERR column flips, one candidate per clock, stopping on the first low-weight residual.
module qr_err_search #(
  parameter int N_POS   = 37,
  parameter int SYN_W   = 36,
  parameter int MAX_ERR = 3,
  parameter int W_TH    = 5,
  localparam int POS_W  = $clog2(N_POS),
  localparam int CNT_W  = $clog2(MAX_ERR + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     col_wr_en,
  input  logic [POS_W-1:0]         col_wr_addr,
  input  logic [SYN_W-1:0]         col_wr_data,
  input  logic                     start,
  input  logic [SYN_W-1:0]         syn_in,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [MAX_ERR*POS_W-1:0] err_pos,
  output logic [SYN_W-1:0]         res_syn
);

  typedef enum logic [1:0] {IDLE, SEARCH, REPORT} state_t;

  state_t                 state;
  logic [SYN_W-1:0]       col_tab [N_POS];
  logic [SYN_W-1:0]       syn_p0;
  logic [CNT_W-1:0]       k_p0;
  logic [POS_W-1:0]       pos_p0  [MAX_ERR];
  logic                   vld_p0;

  logic [SYN_W-1:0]       res_p0;
  logic                   hit_p0;
  logic                   cand_last;
  logic                   exhausted;
  int                     piv;
  logic [POS_W-1:0]       base;
  logic [CNT_W-1:0]       k_nxt;
  logic [POS_W-1:0]       pos_nxt [MAX_ERR];
  logic [MAX_ERR*POS_W-1:0] pos_packed;

  function automatic int popcnt(input logic [SYN_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < SYN_W; i++) n += int'(v[i]);
    return n;
  endfunction

  assign vld_p0 = (state == SEARCH);

  // Stage p0: residual and hit test of the current candidate
  always_comb begin
    res_p0 = syn_p0;
    for (int j = 0; j < MAX_ERR; j++) begin
      if (j < int'(k_p0)) res_p0 = res_p0 ^ col_tab[pos_p0[j]];
    end
  end

  assign hit_p0 = (popcnt(res_p0) <= W_TH);

  // Next combination: bump the rightmost index that still has headroom and
  // repack the tail right behind it; otherwise move on to k+1 at (0,1,..,k).
  always_comb begin
    cand_last = 1'b1;
    piv       = 0;
    base      = '0;
    for (int j = 0; j < MAX_ERR; j++) begin
      if (j < int'(k_p0) && int'(pos_p0[j]) != N_POS - int'(k_p0) + j) begin
        cand_last = 1'b0;
        piv       = j;
        base      = pos_p0[j];
      end
    end
    k_nxt = cand_last ? k_p0 + CNT_W'(1) : k_p0;
    for (int i = 0; i < MAX_ERR; i++) begin
      pos_nxt[i] = '0;
      if (cand_last) begin
        if (i <= int'(k_p0)) pos_nxt[i] = POS_W'(i);
      end else if (i < piv) begin
        pos_nxt[i] = pos_p0[i];
      end else if (i < int'(k_p0)) begin
        pos_nxt[i] = base + POS_W'(i - piv + 1);
      end
    end
  end

  assign exhausted = cand_last && (k_p0 == CNT_W'(MAX_ERR));

  always_comb begin
    pos_packed = '0;
    for (int s = 0; s < MAX_ERR; s++) begin
      if (s < int'(k_p0)) pos_packed[s*POS_W +: POS_W] = pos_p0[s];
    end
  end

  // Latched syndrome is pure data and carries no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !rst) syn_p0 <= syn_in;
  end

  // Stage p1: control FSM, column table and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      err_cnt <= '0;
      err_pos <= '0;
      res_syn <= '0;
      k_p0    <= '0;
      for (int i = 0; i < MAX_ERR; i++) pos_p0[i] <= '0;
      for (int i = 0; i < N_POS; i++) col_tab[i] <= '0;
    end else begin
      done <= 1'b0;
      if (col_wr_en && !vld_p0 && int'(col_wr_addr) < N_POS)
        col_tab[col_wr_addr] <= col_wr_data;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SEARCH;
            busy    <= 1'b1;
            k_p0    <= '0;
            for (int i = 0; i < MAX_ERR; i++) pos_p0[i] <= '0;
            found   <= 1'b0;
            err_cnt <= '0;
            err_pos <= '0;
            res_syn <= '0;
          end
        end
        SEARCH: begin
          if (hit_p0 || exhausted) begin
            state   <= REPORT;
            busy    <= 1'b0;
            done    <= 1'b1;
            found   <= hit_p0;
            err_cnt <= hit_p0 ? k_p0 : '0;
            err_pos <= hit_p0 ? pos_packed : '0;
            res_syn <= hit_p0 ? res_p0 : syn_p0;
          end else begin
            k_p0   <= k_nxt;
            pos_p0 <= pos_nxt;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/qr_err_search.md
# qr_err_search

Sequential, parametrised error-pattern search engine for the QR (73,37) difference-set decoder. It succeeds the single-pattern combinational checker. Given a syndrome, it walks every combination of 0..MAX_ERR information-bit error positions, one candidate per clock. For each candidate it XORs the matching syndrome columns into the syndrome and tests the residual weight against W_TH. It stops on the first hit and reports positions, error count and residual syndrome to the correction stage. The column table is a runtime-loadable register file, so the block is not tied to one generator.

## Interface
- N_POS, 37, number of searchable positions (columns)
- SYN_W, 36, syndrome width
- MAX_ERR, 3, maximum positions flipped per candidate (≥1)
- W_TH, 5, hit when residual weight ≤ W_TH
- localparams: POS_W = clog2(N_POS); CNT_W = clog2(MAX_ERR+1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous and active-high
- col_wr_en  in  1  column table write strobe
- col_wr_addr  in  POS_W  column index; writes with address ≥ N_POS are dropped
- col_wr_data  in  SYN_W  column value
- start  in  1  begin a search; syn_in is sampled on the same edge
- syn_in  in  SYN_W  input syndrome
- busy  out  1  search in progress
- done  out  1  one-cycle pulse at the end of a search
- found  out  1  the last search hit
- err_cnt  out  CNT_W  number of positions in the hit pattern
- err_pos  out  MAX_ERR*POS_W  slot s = bits [s*POS_W +: POS_W]; ascending; unused slots 0
- res_syn  out  SYN_W  residual syndrome of the hit (parity-side error pattern)

## Operation
- FSM states: IDLE, SEARCH, REPORT.
  - IDLE → SEARCH on start. The block latches syn_in, sets k=0 and clears the index registers p[0..MAX_ERR-1].
  - SEARCH → REPORT on a hit, or when the last candidate misses.
  - REPORT → IDLE after exactly 1 cycle.
- Candidate order:
  - k=0 (syndrome alone) first.
  - Then k=1..MAX_ERR. Within each k, p[0]<p[1]<…<p[k-1] in lexicographic order, starting at (0,1,…,k-1).
  - A candidate is the last for its k when p[k-1]=N_POS-1 and every p[j]=N_POS-k+j.
- Total candidates Ntot = Σ C(N_POS,k) for k=0..MAX_ERR. Defaults: 1+37+666+7770 = 8474.
- Residual = latched syndrome XOR col[p[0]] XOR … XOR col[p[k-1]]. Hit when popcount(residual) ≤ W_TH. Popcount is evaluated at full width.
- On hit: found=1, err_cnt=k, err_pos=p (slots ≥k zeroed), res_syn=residual.
- On exhaustion: found=0, err_cnt=0, err_pos=0, res_syn = latched syndrome.
- Result outputs hold until the next accepted start. On that start they clear to 0.
- start is ignored while busy.
- col_wr_en is ignored while busy.
- A write on the same edge a start is accepted takes effect for that search.

## Timing
- Reset values: all outputs 0; column table cleared to 0; FSM in IDLE.
- busy goes 1 the cycle after start is accepted.
- Start accepted in cycle T; candidate n (0-based) is evaluated in cycle T+1+n.
- Hit at candidate n: done=1, found=1 and results are valid in cycle T+n+2. busy falls in that same cycle.
- Exhaustion: done in cycle T+Ntot+1 (defaults: T+8475).
- done is high for exactly one cycle, in REPORT. The earliest next start is accepted in the done cycle+1.
- rst mid-search: the search aborts next edge, all outputs go to 0 and the table is cleared. No done is issued.
- Throughput: exactly one candidate per cycle; no stalls.

## Test plan
Load the default-parameter table with col[i] = 1<<i for i<36 and col[36] = 36'hFFFFFFFFF, then run:
- syn_in=0, start in cycle T → done in T+2; found=1, err_cnt=0, err_pos=0, res_syn=0.
- syn_in=36'h3F → hit at candidate 1; done in T+3; err_cnt=1, slot0=0, res_syn=36'h3E.
- syn_in=36'hFFFFFFFFF → hit at candidate 37 (pos 36); done in T+39; err_cnt=1, slot0=36, res_syn=0.
- syn_in=36'hFF → first k=3 candidate (0,1,2) at index 704; done in T+706; err_pos={0,1,2}, err_cnt=3, res_syn=36'hF8.
- syn_in=36'h1FF → no hit; done in T+8475; found=0, err_cnt=0, res_syn=36'h1FF.
  - Also pulse start and col_wr_en mid-search: both ignored and the result is unchanged.
  - Also assert rst at T+100 of a repeat run: no done, and all outputs read 0 at T+101.
